// File: rtl/bxx_resolve_unit_pkg.sv
// Shared constants and decode types for the branch-resolution unit.
// Also holds the core address width and the fixed instruction length.
package bxx_resolve_unit_pkg;

  localparam int ZCRV_ADDR_SIZE = 32;
  localparam int ZCRV_INSN_LEN  = 4;

  typedef enum logic [1:0] {
    CT_NONE,
    CT_BXX,
    CT_JALR
  } ct_kind_e;

endpackage

// File: rtl/bxx_resolve_unit_fifo.sv
// Synchronous FIFO for predictor-training updates. Pointers carry a wrap bit.
// When the FIFO is full, a push and a pop in the same cycle are both accepted.
module zcrv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
               (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    pop_ok   = pop_i && !empty_o;
    push_ok  = push_i && (!full_o || pop_ok);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    // Zero the head while empty so stale storage never shows on the outputs.
    head_o   = empty_o ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; resetting the pointers is enough to empty the queue.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[IDX_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/bxx_resolve_unit.sv
// Branch/jalr resolution: checks each prediction and issues a registered flush.
// Queues predictor updates for the BPU and keeps saturating statistics counters.
module bxx_resolve_unit
  import bxx_resolve_unit_pkg::*;
#(
  parameter int ADDR_W     = ZCRV_ADDR_SIZE,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter bit JALR_PRED  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_valid_i,
  input  logic              op_bxx_i,
  input  logic              op_jalr_i,
  input  logic              taken_i,
  input  logic              pre_taken_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] dest_i,
  input  logic [ADDR_W-1:0] pre_dest_i,
  output logic              flush_o,
  output logic [ADDR_W-1:0] flush_pc_o,
  output logic              upd_valid_o,
  input  logic              upd_ready_i,
  output logic [ADDR_W-1:0] upd_pc_o,
  output logic              upd_taken_o,
  output logic [CNT_W-1:0]  bxx_cnt_o,
  output logic [CNT_W-1:0]  mis_cnt_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  ct_kind_e          kind;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush_q, flush_d;
  logic [ADDR_W-1:0] flush_pc_q, flush_pc_d;
  logic [CNT_W-1:0]  bxx_cnt_q, bxx_cnt_d;
  logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty, drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // NOTE: every signal gets a default first so no path through always_comb infers a latch.
  always_comb begin
    kind        = CT_NONE;
    mispredict  = 1'b0;
    redirect_pc = dest_i;
    if (res_valid_i) begin
      if (op_bxx_i)       kind = CT_BXX;   // bxx wins if both opcodes are flagged
      else if (op_jalr_i) kind = CT_JALR;
    end
    case (kind)
      CT_BXX: begin
        if (taken_i) begin
          mispredict = !pre_taken_i || (dest_i != pre_dest_i);
        end else begin
          mispredict  = pre_taken_i;
          redirect_pc = pc_i + ADDR_W'(ZCRV_INSN_LEN);
        end
      end
      CT_JALR: mispredict = !JALR_PRED || !pre_taken_i || (dest_i != pre_dest_i);
      default: ;
    endcase
  end

  always_comb begin
    fifo_pop   = !fifo_empty && upd_ready_i;
    fifo_push  = (kind == CT_BXX);
    drop       = fifo_push && fifo_full && !fifo_pop;
    flush_d    = mispredict;
    flush_pc_d = mispredict ? redirect_pc : flush_pc_q;
    bxx_cnt_d  = sat_inc(bxx_cnt_q, fifo_push);
    mis_cnt_d  = sat_inc(mis_cnt_q, mispredict);
    drop_cnt_d = sat_inc(drop_cnt_q, drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
      bxx_cnt_q  <= '0;
      mis_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
      bxx_cnt_q  <= bxx_cnt_d;
      mis_cnt_q  <= mis_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  zcrv_sync_fifo #(
    .WIDTH (ADDR_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_upd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  ({pc_i, taken_i}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  ({upd_pc_o, upd_taken_o})
  );

  assign upd_valid_o = !fifo_empty;
  assign flush_o     = flush_q;
  assign flush_pc_o  = flush_pc_q;
  assign bxx_cnt_o   = bxx_cnt_q;
  assign mis_cnt_o   = mis_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: doc/bxx_resolve_unit.md
# bxx_resolve_unit

Parametrised branch-resolution unit placed after the ID/EX stage. It compares the resolved outcome of conditional branches (bxx) and jalr against the fetch-time prediction, and issues a registered flush with the corrected PC to the flush unit. Predictor training updates are queued in a FIFO and drained to the BPU over a valid/ready handshake. It also keeps saturating statistics counters.

## Interface
Parameters:
- ADDR_W, default `ZCRV_ADDR_SIZE` (32): PC width.
- FIFO_DEPTH, default 4: update-queue entries; power of two, ≥2.
- CNT_W, default 16: width of each statistics counter.
- JALR_PRED, default 0: 1 means a jalr with a correct predicted target does not flush; 0 means every jalr flushes.

Ports (one clock `clk`; reset `rst_n` is asynchronous and active-low):
- clk  in  1  core clock
- rst_n  in  1  async active-low reset
- res_valid_i  in  1  a resolved control-transfer instruction is present this cycle
- op_bxx_i  in  1  instruction is a conditional branch
- op_jalr_i  in  1  instruction is a jalr
- taken_i  in  1  resolved branch direction (ignored for jalr; jalr is always taken)
- pre_taken_i  in  1  fetch predicted taken
- pc_i  in  ADDR_W  instruction PC
- dest_i  in  ADDR_W  resolved target
- pre_dest_i  in  ADDR_W  predicted target
- flush_o  out  1  redirect request to flush unit (registered)
- flush_pc_o  out  ADDR_W  redirect PC (registered)
- upd_valid_o  out  1  update entry available for BPU
- upd_ready_i  in  1  BPU accepts the head entry
- upd_pc_o  out  ADDR_W  head entry PC
- upd_taken_o  out  1  head entry outcome
- bxx_cnt_o  out  CNT_W  resolved bxx count
- mis_cnt_o  out  CNT_W  mispredict count (bxx + jalr)
- drop_cnt_o  out  CNT_W  updates dropped because the FIFO was full

## Operation
- res_valid_i low, or both op_bxx_i and op_jalr_i low: no flush, no push, no count.
- op_bxx_i and op_jalr_i high together is illegal; the bxx interpretation is used.
- bxx mispredicts when any of the following holds:
  - taken_i=1 and pre_taken_i=0: redirect to dest_i.
  - taken_i=0 and pre_taken_i=1: redirect to pc_i+4, truncated to ADDR_W.
  - taken_i=1, pre_taken_i=1 and dest_i≠pre_dest_i: redirect to dest_i.
- jalr mispredicts when JALR_PRED=0. When JALR_PRED=1 it mispredicts only if pre_taken_i=0 or dest_i≠pre_dest_i. The redirect PC is dest_i.
- Every valid bxx:
  - pushes {pc_i, taken_i} into the update FIFO if a slot is free, otherwise increments drop_cnt.
  - increments bxx_cnt.
- jalr never pushes to the FIFO.
- Every mispredict increments mis_cnt.
- All counters saturate at 2^CNT_W−1.
- FIFO behaviour:
  - upd_valid_o = not empty; upd_pc_o and upd_taken_o show the head entry.
  - Pop on upd_valid_o & upd_ready_i.
  - When full, a push and a pop in the same cycle are both accepted: the count is unchanged and nothing is dropped.
  - Pointers are log2(FIFO_DEPTH)+1 bits with a wrap bit. Full = same index, different wrap bit.
- A flush does not clear the FIFO; entries are resolved-path and remain valid.
- Reset values: flush_o=0, flush_pc_o=0, FIFO empty (upd_valid_o=0, upd_pc_o=0, upd_taken_o=0), all counters 0. Reset asserted mid-operation discards queued entries immediately.

## Timing
- flush_o and flush_pc_o are registered, with 1-cycle latency from res_valid_i. flush_o is high for exactly one cycle per mispredict. flush_pc_o holds its last value when flush_o=0.
- Back-to-back mispredicts on consecutive cycles give consecutive flush pulses.
- A push is visible on upd_valid_o the next cycle; there is no same-cycle bypass.
- upd_ready_i may be asserted without upd_valid_o. A pop on an empty FIFO is ignored.
- Counters update on the cycle after the event.

## Structure
- `ZCRV_ADDR_SIZE` and the instruction length constant (4) live in the shared defines file.
- The update queue is one sub-module, `zcrv_sync_fifo`, parametrised on width and depth, with push, pop, full, empty and head outputs.
- Mispredict and redirect logic plus the counters stay in the top module.

## Test plan
- bxx, pc=0x100, taken=1, pre_taken=0, dest=0x200 → next cycle flush_o=1, flush_pc_o=0x200; FIFO head {0x100,1}; bxx_cnt=1, mis_cnt=1.
- bxx, pc=0xFFFFFFFC, taken=0, pre_taken=1 → flush_pc_o=0x00000000 (wrap); head {0xFFFFFFFC,0}.
- bxx, taken=1, pre_taken=1, dest=pre_dest=0x300 → no flush, push; same with pre_dest=0x304 → flush to 0x300.
- jalr, dest=pre_dest=0x400, pre_taken=1 → JALR_PRED=0: flush to 0x400; JALR_PRED=1: no flush. In both cases no push.
- FIFO_DEPTH=4, upd_ready_i=0, 6 bxx → 4 queued, drop_cnt=2. Then ready=1 with a simultaneous push while full → push accepted, no drop, order preserved.
- Reset pulsed with 3 queued entries → upd_valid_o=0 immediately, all counters 0, flush_o=0.
